// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline and the control sequencer.
//   master: hazard requests in (load_use_stall, ex_redirect, dmem_req, dmem_ready)
//   slave : per-stage hold/flush/bubble controls, sticky timeout and counters out
`timescale 1ns/1ps
interface pipe_hazard_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use_stall;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic             exmem_hold;
  logic             memwb_bubble;
  logic             dmem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output load_use_stall, ex_redirect, dmem_req, dmem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
    input  exmem_hold, memwb_bubble, dmem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  load_use_stall, ex_redirect, dmem_req, dmem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
    output exmem_hold, memwb_bubble, dmem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-control sequencer for the 5-stage core: turns load-use, redirect
// and data-memory handshake requests into per-stage hold/flush/bubble controls.
//   clk, rst_n : core clock (rising edge), asynchronous active-low reset
//   hz (slave) : hazard requests in; stage controls, timeout flag, counters out
// Stage controls are combinational from state and inputs; state, the sticky
// timeout flag and the saturating counters are registered.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst_n,
  pipe_hazard_if.slave  hz
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              redirect_pend, redirect_pend_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              dmem_timeout_q;
  logic [CNT_W-1:0]  stall_cycles_q, flush_count_q;

  logic freeze, flush, lu_stall, timeout_hit;

  // Next-state and stage-control decode
  always_comb begin
    state_nxt         = state;
    redirect_pend_nxt = redirect_pend;
    wait_cnt_nxt      = '0;
    freeze            = 1'b0;
    flush             = 1'b0;
    lu_stall          = 1'b0;
    timeout_hit       = 1'b0;
    unique case (state)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          // Redirect arriving with the freeze is replayed after the wait
          freeze            = 1'b1;
          state_nxt         = MEM_WAIT;
          redirect_pend_nxt = redirect_pend | hz.ex_redirect;
        end else if (hz.ex_redirect) begin
          // Consumer in ID is wrong-path, so any load-use stall is dropped
          flush = 1'b1;
        end else if (hz.load_use_stall) begin
          lu_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_nxt = redirect_pend ? FLUSH : RUN;
        end else begin
          freeze       = 1'b1;
          timeout_hit  = (wait_cnt == WAIT_LAST);
          // Hold at the limit so the counter cannot wrap on a hung access
          wait_cnt_nxt = timeout_hit ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
      end
      FLUSH: begin
        flush             = 1'b1;
        redirect_pend_nxt = 1'b0;
        state_nxt         = RUN;
      end
      default: begin
        state_nxt         = RUN;
        redirect_pend_nxt = 1'b0;
      end
    endcase
    // Controls are quiet while reset is held, whatever the inputs do
    if (!rst_n) begin
      freeze   = 1'b0;
      flush    = 1'b0;
      lu_stall = 1'b0;
    end
  end

  assign hz.pc_hold      = freeze | lu_stall;
  assign hz.ifid_hold    = freeze | lu_stall;
  assign hz.ifid_flush   = flush;
  assign hz.idex_hold    = freeze;
  assign hz.idex_bubble  = flush | lu_stall;
  assign hz.exmem_hold   = freeze;
  assign hz.memwb_bubble = freeze;
  assign hz.dmem_timeout = dmem_timeout_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

  // State, wait counter and pending-redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= redirect_pend_nxt;
      wait_cnt      <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (timeout_hit) dmem_timeout_q <= 1'b1;
      if (hz.pc_hold && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (flush && (flush_count_q != '1))
        flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized hazard traffic, compared cycle by cycle to a behavioural model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned TIMEOUT = 4;
  localparam longint     CNT_MAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipe_hazard_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: waiting flag, deferred redirect, pending flush cycle,
  // count of unanswered wait cycles, and the externally visible counters.
  bit     m_wait, m_pend, m_flush_now, m_to;
  int     m_wait_seen;
  longint m_stall, m_flushes;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold,
            hz.idex_bubble, hz.exmem_hold, hz.memwb_bubble};
  endfunction

  // Expected {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble}
  function automatic logic [6:0] model_ctrl(input bit lus, input bit red, input bit req, input bit rdy);
    logic [6:0] frz, fl, lu;
    frz = 7'b1101011;
    fl  = 7'b0010100;
    lu  = 7'b1100100;
    if (m_flush_now)      return fl;
    if (m_wait)           return rdy ? 7'b0 : frz;
    if (req && !rdy)      return frz;
    if (red)              return fl;
    if (lus)              return lu;
    return 7'b0;
  endfunction

  function automatic void model_reset();
    m_wait = 0; m_pend = 0; m_flush_now = 0; m_to = 0;
    m_wait_seen = 0; m_stall = 0; m_flushes = 0;
  endfunction

  function automatic void model_clock(input bit lus, input bit red, input bit req, input bit rdy);
    logic [6:0] c;
    c = model_ctrl(lus, red, req, rdy);
    if (c[6]) m_stall   = (m_stall   < CNT_MAX) ? m_stall + 1   : CNT_MAX;
    if (c[4]) m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
    if (m_flush_now) begin
      m_flush_now = 0;
      m_pend      = 0;
    end else if (m_wait) begin
      if (rdy) begin
        m_wait      = 0;
        m_flush_now = m_pend;
        m_pend      = 0;
        m_wait_seen = 0;
      end else begin
        m_wait_seen++;
        if (m_wait_seen >= TIMEOUT) m_to = 1;
      end
    end else if (req && !rdy) begin
      m_wait      = 1;
      m_pend      = m_pend | red;
      m_wait_seen = 0;
    end
  endfunction

  // One clock: drive at negedge, check combinational controls and registered
  // state before the rising edge, advance the model on the edge.
  task automatic step(input bit lus, input bit red, input bit req, input bit rdy);
    @(negedge clk);
    hz.load_use_stall = lus;
    hz.ex_redirect    = red;
    hz.dmem_req       = req;
    hz.dmem_ready     = rdy;
    #1;
    chk("ctrl", 64'(dut_ctrl()), 64'(model_ctrl(lus, red, req, rdy)));
    chk("stall_cycles", 64'(hz.stall_cycles), 64'(m_stall));
    chk("flush_count", 64'(hz.flush_count), 64'(m_flushes));
    chk("dmem_timeout", 64'(hz.dmem_timeout), 64'(m_to));
    chk("inv_ifid", 64'(hz.ifid_hold & hz.ifid_flush), 64'd0);
    chk("inv_idex", 64'(hz.idex_hold & hz.idex_bubble), 64'd0);
    assert (!(hz.ifid_hold && hz.ifid_flush) && !(hz.idex_hold && hz.idex_bubble));
    @(posedge clk);
    model_clock(lus, red, req, rdy);
    #1;
  endtask

  // Assert reset between edges with the inputs left as they are, then
  // release on a falling edge with the inputs idle.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ctrl", 64'(dut_ctrl()), 64'd0);
    chk("rst_stall", 64'(hz.stall_cycles), 64'd0);
    chk("rst_flush", 64'(hz.flush_count), 64'd0);
    chk("rst_timeout", 64'(hz.dmem_timeout), 64'd0);
    @(negedge clk);
    hz.load_use_stall = 0;
    hz.ex_redirect    = 0;
    hz.dmem_req       = 0;
    hz.dmem_ready     = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    hz.load_use_stall = 0;
    hz.ex_redirect    = 0;
    hz.dmem_req       = 0;
    hz.dmem_ready     = 0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Single load-use stall
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("lu_stall_cnt", 64'(hz.stall_cycles), 64'd1);

    // Redirect overrides a concurrent load-use stall
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("redir_flush_cnt", 64'(hz.flush_count), 64'd1);
    chk("redir_stall_cnt", 64'(hz.stall_cycles), 64'd1);

    // Three-cycle memory wait, then release
    do_reset();
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("wait3_stall_cnt", 64'(hz.stall_cycles), 64'd3);
    chk("wait3_flush_cnt", 64'(hz.flush_count), 64'd0);

    // Redirect on wait entry is replayed as a single flush after release
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pend_flush_cnt", 64'(hz.flush_count), 64'd1);
    chk("pend_stall_cnt", 64'(hz.stall_cycles), 64'd2);

    // Timeout after TIMEOUT unanswered wait cycles, sticky past ready
    do_reset();
    step(0, 0, 1, 0);
    repeat (TIMEOUT - 1) step(0, 0, 1, 0);
    chk("to_early", 64'(hz.dmem_timeout), 64'd0);
    step(0, 0, 1, 0);
    chk("to_set", 64'(hz.dmem_timeout), 64'd1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("to_sticky", 64'(hz.dmem_timeout), 64'd1);

    // Reset in the middle of a wait with a pending redirect
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_no_flush", 64'(hz.flush_count), 64'd0);

    // Counter saturation
    do_reset();
    repeat (CNT_MAX + 5) step(1, 0, 0, 0);
    chk("stall_sat", 64'(hz.stall_cycles), 64'(CNT_MAX));
    repeat (CNT_MAX + 5) step(0, 1, 0, 0);
    chk("flush_sat", 64'(hz.flush_count), 64'(CNT_MAX));

    // Randomized hazard traffic with occasional mid-stream resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      step($urandom_range(99) < 25, $urandom_range(99) < 15,
           $urandom_range(99) < 40, $urandom_range(99) < 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline-control sequencer for the 5-stage RV64I core. It consumes hazard requests and drives per-stage hold, flush and bubble controls:
- load-use stall request from the ID/EX hazard detector
- branch/jump redirect from EX
- data-memory handshake from MEM
It owns the multi-cycle data-memory wait state machine, defers a redirect that arrives during a memory wait, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter
TIMEOUT, 64, MEM_WAIT cycles before dmem_timeout is raised (must be >= 2)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_use_stall  input  1  load-use hazard: consumer in ID, load in EX
ex_redirect  input  1  EX resolved a taken branch or jump (one-cycle pulse)
dmem_req  input  1  MEM stage has a valid load or store this cycle
dmem_ready  input  1  data memory completes the request this cycle
pc_hold  output  1  PC register keeps its value
ifid_hold  output  1  IF/ID register keeps its value
ifid_flush  output  1  IF/ID register loads a NOP
idex_hold  output  1  ID/EX register keeps its value
idex_bubble  output  1  ID/EX register loads a NOP (Enable cleared)
exmem_hold  output  1  EX/MEM register keeps its value
memwb_bubble  output  1  MEM/WB register loads a NOP
dmem_timeout  output  1  sticky error flag
stall_cycles  output  CNT_W  count of cycles with pc_hold=1
flush_count  output  CNT_W  count of redirect flushes applied

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, redirect_pend=0, wait_cnt=0.
  - Counters=0, dmem_timeout=0.
  - All control outputs 0.
- Control outputs are combinational from state, redirect_pend and the inputs. State and counters are registered.
- State RUN, priority order:
  1. dmem_req=1 and dmem_ready=0:
     - freeze: pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_bubble = 1.
     - next state MEM_WAIT.
     - A concurrent ex_redirect sets redirect_pend=1 and produces no flush now.
  2. else ex_redirect=1:
     - ifid_flush=1, idex_bubble=1.
     - load_use_stall is ignored in that cycle because the consumer is wrong-path.
     - flush_count increments.
  3. else load_use_stall=1:
     - pc_hold=1, ifid_hold=1, idex_bubble=1.
     - Exactly one bubble per asserted cycle.
  4. else all controls 0.
- State MEM_WAIT:
  - Freeze outputs as in RUN item 1. wait_cnt increments every cycle.
  - ex_redirect is ignored here; EX is frozen, so the redirect was captured on entry.
  - On dmem_ready=1:
    - Outputs in that cycle are all 0 (release); wait_cnt clears.
    - Next state is FLUSH if redirect_pend=1, else RUN.
  - When wait_cnt reaches TIMEOUT-1 without ready: dmem_timeout is set sticky (cleared only by reset). State remains MEM_WAIT.
- State FLUSH (one cycle):
  - ifid_flush=1, idex_bubble=1, redirect_pend cleared, flush_count increments.
  - Next state RUN.
- dmem_req=1 with dmem_ready=1 in the same cycle in RUN: zero-wait access, no freeze.
- stall_cycles increments in every cycle where pc_hold=1.
- Both counters saturate at all-ones and do not wrap.
- A hold and a flush/bubble on the same register are never asserted together; the bench asserts this as an invariant.
- Reset mid-wait: returns to RUN immediately and discards redirect_pend.

Test Plan:
- Single load-use: load_use_stall=1 for 1 cycle in RUN -> pc_hold=ifid_hold=idex_bubble=1 that cycle only; stall_cycles=1.
- Redirect with stall: ex_redirect=1 and load_use_stall=1 together -> ifid_flush=idex_bubble=1, pc_hold=0; flush_count=1.
- 3-cycle memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> freeze outputs for 3 cycles, then release cycle with all 0; stall_cycles=3; state RUN.
- Redirect during wait entry: dmem_req=1, dmem_ready=0, ex_redirect=1; ready after 2 cycles -> 2 freeze cycles, 1 release cycle, then one FLUSH cycle (ifid_flush=1); flush_count=1.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> dmem_timeout=1 after the 4th MEM_WAIT cycle and stays 1 after ready arrives.
- Async reset mid-MEM_WAIT with redirect_pend=1: rst_n low between clock edges -> outputs and counters 0 immediately; no FLUSH after release.
